// File: rtl/filter_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : filter_seq_ctrl
//  Description : Sequencer for the IQ-demod low-pass filter. Divides the
//                clock down to the sample rate and pulses the filter strobe
//                once per tick. It waits on filt_pret with a timeout and
//                captures the filtered result. On enable it first pushes
//                zero samples to flush the filter history. Dropped ticks
//                and timeouts are reported.
//  Revision    : 1.0  initial release
// ============================================================================
module filter_seq_ctrl #(
  parameter int DATA_W  = 5,
  parameter int PERIOD  = 5,
  parameter int NFLUSH  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic              err_clr,
  input  logic [DATA_W-1:0] din,
  input  logic              filt_pret,
  input  logic [DATA_W-1:0] filt_dout,
  output logic              filt_valid,
  output logic [DATA_W-1:0] filt_din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              err,
  output logic [7:0]        ovr_cnt
);

  localparam int c_tick_w = $clog2(PERIOD);
  localparam int c_to_w   = $clog2(TIMEOUT + 1);
  localparam int c_fl_w   = $clog2(NFLUSH + 2);

  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(PERIOD - 1);
  localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(TIMEOUT - 1);
  localparam logic [c_fl_w-1:0]   c_fl_last   = c_fl_w'((NFLUSH > 0) ? NFLUSH - 1 : 0);
  localparam bit                  c_has_flush = (NFLUSH > 0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FLUSH_STB = 3'd1,
    S_WAIT_TICK = 3'd2,
    S_STROBE    = 3'd3,
    S_WAIT_RDY  = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_flush;
  logic [c_fl_w-1:0]   r_flush_cnt;
  logic [c_to_w-1:0]   r_to_cnt;
  logic [c_tick_w-1:0] r_tick_cnt;
  logic                w_tick;
  logic                w_ovr;
  logic [7:0]          w_ovr_next;

  // A tick is only produced while enabled and outside the flush phase.
  assign w_tick = en && !r_flush && (r_tick_cnt == c_tick_last);
  // A tick that finds the FSM anywhere but WAIT_TICK is a lost sample.
  assign w_ovr  = w_tick && (r_state != S_WAIT_TICK);
  // Clearing in the same cycle as an overrun still records that overrun.
  assign w_ovr_next = err_clr ? 8'd1 :
                      ((ovr_cnt == 8'hFF) ? 8'hFF : ovr_cnt + 8'd1);
  assign busy = (r_state != S_IDLE) && (r_state != S_WAIT_TICK);

  // Sample-rate divider: free-runs while enabled, parked at zero otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tick_cnt <= '0;
    end else if (!en || r_flush || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Sequencer FSM with registered strobe, capture and status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_flush     <= 1'b0;
      r_flush_cnt <= '0;
      r_to_cnt    <= '0;
      filt_valid  <= 1'b0;
      filt_din    <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      err         <= 1'b0;
      ovr_cnt     <= '0;
    end else begin
      filt_valid <= 1'b0;
      dout_valid <= 1'b0;
      if (err_clr) begin
        err     <= 1'b0;
        ovr_cnt <= '0;
      end
      if (w_ovr) begin
        ovr_cnt <= w_ovr_next;
      end
      case (r_state)
        S_IDLE: begin
          if (en) begin
            if (c_has_flush) begin
              r_flush     <= 1'b1;
              r_flush_cnt <= '0;
              filt_din    <= '0;
              filt_valid  <= 1'b1;
              r_state     <= S_FLUSH_STB;
            end else begin
              r_state <= S_WAIT_TICK;
            end
          end
        end
        S_FLUSH_STB: begin
          r_to_cnt <= '0;
          r_state  <= S_WAIT_RDY;
        end
        S_WAIT_TICK: begin
          if (!en) begin
            r_state <= S_IDLE;
          end else if (w_tick) begin
            filt_din   <= din;
            filt_valid <= 1'b1;
            r_state    <= S_STROBE;
          end
        end
        S_STROBE: begin
          r_to_cnt <= '0;
          r_state  <= S_WAIT_RDY;
        end
        S_WAIT_RDY: begin
          r_to_cnt <= r_to_cnt + 1'b1;
          // The first cycle ignores pret: the filter may not have dropped it yet.
          if ((r_to_cnt != '0) && filt_pret) begin
            if (r_flush) begin
              r_flush_cnt <= r_flush_cnt + 1'b1;
              if (!en) begin
                r_flush <= 1'b0;
                r_state <= S_IDLE;
              end else if (r_flush_cnt == c_fl_last) begin
                r_flush <= 1'b0;
                r_state <= S_WAIT_TICK;
              end else begin
                filt_valid <= 1'b1;
                r_state    <= S_FLUSH_STB;
              end
            end else begin
              dout       <= filt_dout;
              dout_valid <= 1'b1;
              r_state    <= en ? S_WAIT_TICK : S_IDLE;
            end
          end else if (r_to_cnt == c_to_last) begin
            err     <= 1'b1;
            r_flush <= 1'b0;
            r_state <= en ? S_WAIT_TICK : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_filter_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_filter_seq_ctrl
//  Description : Directed bench for filter_seq_ctrl with a small filter model
//                (output = input xor 0x0A, pret back lat cycles after strobe).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_filter_seq_ctrl;

  localparam int PERIOD = 5;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       en = 1'b0;
  logic       err_clr = 1'b0;
  logic [4:0] din = 5'h00;
  logic       filt_pret;
  logic [4:0] filt_dout;
  logic       filt_valid;
  logic [4:0] filt_din;
  logic [4:0] dout;
  logic       dout_valid;
  logic       busy;
  logic       err;
  logic [7:0] ovr_cnt;

  filter_seq_ctrl #(.DATA_W(5), .PERIOD(5), .NFLUSH(4), .TIMEOUT(64)) dut (
    .clk(clk), .resetn(resetn), .en(en), .err_clr(err_clr), .din(din),
    .filt_pret(filt_pret), .filt_dout(filt_dout), .filt_valid(filt_valid),
    .filt_din(filt_din), .dout(dout), .dout_valid(dout_valid), .busy(busy),
    .err(err), .ovr_cnt(ovr_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Filter model: pret returns lat cycles after the strobe cycle.
  int         lat = 2;
  bit         hang = 1'b0;
  int         m_cnt;
  logic [4:0] m_out;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_cnt <= 0;
      m_out <= 5'h00;
    end else if (filt_valid) begin
      m_cnt <= lat - 1;
      m_out <= filt_din ^ 5'h0A;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
  end
  assign filt_pret = !hang && (m_cnt == 0);
  assign filt_dout = m_out;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int at, output bit ok);
    ok = 1'b0; at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (filt_valid === 1'b1) begin ok = 1'b1; at = cyc; return; end
    end
  endtask

  task automatic wait_dv(input int budget, output int at, output bit ok);
    ok = 1'b0; at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dout_valid === 1'b1) begin ok = 1'b1; at = cyc; return; end
    end
  endtask

  // Counts zero-sample strobes until the first non-zero (real) strobe.
  task automatic count_flush(output int nfl, output int ndv, output int at, output bit ok);
    nfl = 0; ndv = 0; at = -1; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dout_valid === 1'b1) ndv++;
      if (filt_valid === 1'b1) begin
        if (filt_din == 5'h00) nfl++;
        else begin ok = 1'b1; at = cyc; return; end
      end
    end
  endtask

  typedef struct {
    logic [4:0] din;
    logic [4:0] exp;
  } vec_t;
  vec_t vec[8];

  initial begin
    int  at, at2, prev, nfl, ndv, nv;
    bit  ok;

    vec[0] = '{5'h15, 5'h1F};
    vec[1] = '{5'h01, 5'h0B};
    vec[2] = '{5'h00, 5'h0A};
    vec[3] = '{5'h0A, 5'h00};
    vec[4] = '{5'h1F, 5'h15};
    vec[5] = '{5'h10, 5'h1A};
    vec[6] = '{5'h0F, 5'h05};
    vec[7] = '{5'h1A, 5'h10};

    // Reset with enable and data active.
    en = 1'b1; din = 5'h1F;
    repeat (3) @(negedge clk);
    chk("rst_filt_valid", 32'(filt_valid), 0);
    chk("rst_filt_din",   32'(filt_din),   0);
    chk("rst_dout",       32'(dout),       0);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_busy",       32'(busy),       0);
    chk("rst_err",        32'(err),        0);
    chk("rst_ovr_cnt",    32'(ovr_cnt),    0);

    // Flush then steady state.
    en = 1'b0; din = vec[0].din;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b1;
    count_flush(nfl, ndv, at, ok);
    chk("flush_real_seen", 32'(ok), 1);
    chk("flush_count", 32'(nfl), 4);
    chk("flush_no_dv", 32'(ndv), 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        wait_valid(20, at, ok);
        chk("ss_valid_seen", 32'(ok), 1);
        chk("ss_tick_gap", 32'(at - prev), PERIOD);
      end
      chk("ss_filt_din", 32'(filt_din), 32'(vec[i].din));
      prev = at;
      din = (i < 7) ? vec[i+1].din : 5'h07;
      wait_dv(20, at2, ok);
      chk("ss_dv_seen", 32'(ok), 1);
      chk("ss_latency", 32'(at2 - prev), 3);
      chk("ss_dout", 32'(dout), 32'(vec[i].exp));
    end
    chk("ss_ovr_cnt", 32'(ovr_cnt), 0);
    chk("ss_err", 32'(err), 0);

    // Disable while a transaction is in flight.
    wait_valid(20, at, ok);
    chk("dis_valid_seen", 32'(ok), 1);
    en = 1'b0;
    wait_dv(10, at2, ok);
    chk("dis_dv_seen", 32'(ok), 1);
    chk("dis_dout", 32'(dout), 32'h0D);
    repeat (2) @(negedge clk);
    chk("dis_idle_busy", 32'(busy), 0);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (filt_valid) nv++;
    end
    chk("dis_no_strobe", 32'(nv), 0);

    // Re-enable re-flushes; then reset while strobing.
    en = 1'b1;
    count_flush(nfl, ndv, at, ok);
    chk("reen_real_seen", 32'(ok), 1);
    chk("reen_flush_count", 32'(nfl), 4);
    chk("reen_no_dv", 32'(ndv), 0);
    chk("reen_busy", 32'(busy), 1);
    resetn = 1'b0;
    #1;
    chk("mrst_filt_valid", 32'(filt_valid), 0);
    chk("mrst_filt_din", 32'(filt_din), 0);
    chk("mrst_dout", 32'(dout), 0);
    chk("mrst_busy", 32'(busy), 0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst_no_dv", 32'(dout_valid), 0);

    // Overrun: filter slower than the sample period.
    resetn = 1'b1; lat = 8; din = 5'h03;
    @(negedge clk);
    en = 1'b1;
    count_flush(nfl, ndv, at, ok);
    chk("ovr_real_seen", 32'(ok), 1);
    chk("ovr_flush_count", 32'(nfl), 4);
    prev = at;
    wait_valid(20, at, ok);
    chk("ovr_gap1", 32'(at - prev), 10);
    chk("ovr_cnt1", 32'(ovr_cnt), 1);
    prev = at;
    wait_valid(20, at, ok);
    chk("ovr_gap2", 32'(at - prev), 10);
    chk("ovr_cnt2", 32'(ovr_cnt), 2);
    repeat (4) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ovr_clr_vs_inc", 32'(ovr_cnt), 1);
    repeat (2700) @(negedge clk);
    chk("ovr_saturate", 32'(ovr_cnt), 255);
    chk("ovr_no_err", 32'(err), 0);
    en = 1'b0;
    repeat (20) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ovr_cleared", 32'(ovr_cnt), 0);

    // Timeout: pret stuck low after a strobe.
    lat = 2; din = 5'h09;
    en = 1'b1;
    count_flush(nfl, ndv, at, ok);
    chk("to_real_seen", 32'(ok), 1);
    hang = 1'b1;
    repeat (60) @(negedge clk);
    chk("to_err_early", 32'(err), 0);
    repeat (6) @(negedge clk);
    chk("to_err_set", 32'(err), 1);
    chk("to_busy", 32'(busy), 0);
    hang = 1'b0;
    wait_valid(12, at, ok);
    chk("to_restrobe", 32'(ok), 1);
    chk("to_filt_din", 32'(filt_din), 32'h09);
    wait_dv(10, at2, ok);
    chk("to_dv_seen", 32'(ok), 1);
    chk("to_dout", 32'(dout), 32'h03);
    chk("to_err_sticky", 32'(err), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("to_err_cleared", 32'(err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
